// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I instruction descriptors into 32-bit words,
// queues them in a small FIFO and emits each word with a sequential byte
// address for instruction-memory loading.
// Optional build macro: INST_ENC_CHECK_EN (range-check descriptors, drive err).
module inst_encoder #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          ADDR_W     = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LP_FULL = CNT_W'(FIFO_DEPTH);

  // Format codes
  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_U = 3'b010;
  localparam logic [2:0] FMT_B = 3'b101;
  localparam logic [2:0] FMT_J = 3'b110;
  localparam logic [2:0] FMT_R = 3'b111;

  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr;

  logic [31:0] w_word;
  logic        w_fmt_ok;
  logic        w_is_shift;
  logic        w_chk_ok;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // Shift-immediate variants of OP-IMM carry funct7 in the upper bits
  assign w_is_shift = (opcode == 7'b0010011) && ((funct3 == 3'b001) || (funct3 == 3'b101));

  // Pack descriptor fields into the instruction word for each format
  always_comb begin
    w_word   = '0;
    w_fmt_ok = 1'b1;
    case (fmt)
      FMT_R: w_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (w_is_shift) w_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else            w_word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: w_word = {imm[31:12], rd, opcode};
      FMT_J: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_fmt_ok = 1'b0;  // reserved formats are consumed and dropped
    endcase
  end

`ifdef INST_ENC_CHECK_EN
  logic r_err;
  logic w_fit12;
  logic w_fit13;
  logic w_fit21;

  // A value sign-fits N bits when bits [31:N-1] are all equal
  assign w_fit12 = (&imm[31:11]) || (~|imm[31:11]);
  assign w_fit13 = (&imm[31:12]) || (~|imm[31:12]);
  assign w_fit21 = (&imm[31:20]) || (~|imm[31:20]);

  // Decide whether the immediate is representable in the selected format
  always_comb begin
    w_chk_ok = 1'b1;
    case (fmt)
      FMT_R: w_chk_ok = 1'b1;
      FMT_I: w_chk_ok = w_fit12 && (!w_is_shift || (imm[11:5] == 7'd0));
      FMT_S: w_chk_ok = w_fit12;
      FMT_B: w_chk_ok = w_fit13 && !imm[0];
      FMT_J: w_chk_ok = w_fit21 && !imm[0];
      FMT_U: w_chk_ok = (imm[11:0] == 12'd0);
      default: w_chk_ok = 1'b0;
    endcase
  end

  // Sticky error: only reset clears it, flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_err <= 1'b0;
    else if (w_accept && !w_chk_ok)  r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_chk_ok = 1'b1;
  assign err      = 1'b0;
`endif

  assign w_full    = (r_count == LP_FULL);
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full || flush;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_fmt_ok && w_chk_ok && !flush;
  assign w_pop     = !w_empty && out_ready && !flush;

  assign out_valid = !w_empty;
  assign out_instr = w_empty ? 32'd0 : r_mem[r_rd_ptr];
  assign out_addr  = r_addr;

  // Storage array: written on push, no reset needed since count gates reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // Pointers, occupancy and emitted-address tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= LP_BASE;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= LP_BASE;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_addr   <= r_addr + ADDR_W'(4);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed test of inst_encoder with an expected-word
// scoreboard. Words are queued when a descriptor is accepted and compared,
// together with their address, when the encoder hands them out.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic        err;

  logic [31:0] exp_q[$];
  logic [9:0]  exp_addr;
  logic        drive_push;
  logic [31:0] drive_word;
  int          pass_cnt;
  int          total_cnt;

  always #5 clk = ~clk;

  inst_encoder #(.FIFO_DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: pops/compares on output handshakes, pushes on accepted inputs
  task automatic monitor();
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        exp_q.delete();
        exp_addr = '0;
      end else begin
        if (out_valid && out_ready) begin
          total_cnt++;
          assert (exp_q.size() != 0) pass_cnt++;
          else $error("FAIL unexpected_word: observed %h expected none", out_instr);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("out_instr", out_instr, w);
            chk("out_addr", 32'(out_addr), 32'(exp_addr));
            $display("pop  instr=%h addr=%h", out_instr, out_addr);
            exp_addr = exp_addr + 10'd4;
          end
        end
        if (in_valid && in_ready && drive_push) begin
          exp_q.push_back(drive_word);
          $display("push expect=%h", drive_word);
        end
      end
    end
  endtask

  task automatic set_desc(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [31:0] im,
                          input logic push_exp, input logic [31:0] exp_w);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    drive_push = push_exp; drive_word = exp_w;
  endtask

  // Present the current descriptor until it is accepted (bounded)
  task automatic handshake();
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive_push = 1'b0;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im,
                      input logic push_exp, input logic [31:0] exp_w);
    set_desc(f, op, f3, f7, d, s1, s2, im, push_exp, exp_w);
    handshake();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    pass_cnt = 0; total_cnt = 0;
    exp_addr = '0; drive_push = 1'b0; drive_word = '0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_desc(3'b000, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_instr", out_instr,      32'd0);
    chk("rst_out_addr",  32'(out_addr),  32'd0);
    chk("rst_err",       32'(err),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // addi x1,x2,5: word visible only on the cycle after the push edge
    out_ready = 1'b1;
    set_desc(3'b000, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5, 1'b1, 32'h00510093);
    in_valid = 1'b1;
    chk("no_passthrough", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; drive_push = 1'b0;
    chk("valid_next", 32'(out_valid), 32'd1);
    drain();

    // R, S, I-shift and B encodings back-to-back
    do_flush();
    send(3'b111, 7'b0110011, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    send(3'b001, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd6, 5'd5, 32'd8, 1'b1, 32'h00532423);
    send(3'b000, 7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd3, 1'b1, 32'h4030D093);
    send(3'b101, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3);
    drain();

    // Fill the FIFO with backpressure, then release it
    do_flush();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send(3'b010, 7'b0110111, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k) << 12, 1'b1,
           (32'(k) << 12) | (32'(k) << 7) | 32'h37);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    set_desc(3'b010, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd5 << 12, 1'b1,
             (32'd5 << 12) | (32'd5 << 7) | 32'h37);
    in_valid = 1'b1;
    held = out_instr;
    repeat (3) begin
      @(posedge clk); #1;
      chk("held_in_ready", 32'(in_ready), 32'd0);
      chk("held_instr", out_instr, held);
      chk("held_addr", 32'(out_addr), 32'd0);
    end
    out_ready = 1'b1;
    handshake();
    drain();

    // Flush with a concurrent push discards everything
    do_flush();
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++)
      send(3'b010, 7'b0110111, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k) << 12, 1'b1,
           (32'(k) << 12) | (32'(k) << 7) | 32'h37);
    set_desc(3'b000, 7'b0010011, 3'b000, 7'd0, 5'd7, 5'd7, 5'd0, 32'd1, 1'b0, 32'd0);
    in_valid = 1'b1; flush = 1'b1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_addr", 32'(out_addr), 32'd0);
    out_ready = 1'b1;
    send(3'b000, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5, 1'b1, 32'h00510093);
    drain();

    // Asynchronous reset in the middle of a cycle
    out_ready = 1'b0;
    send(3'b111, 7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    send(3'b111, 7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_instr", out_instr,      32'd0);
    chk("arst_out_addr",  32'(out_addr),  32'd0);
    chk("arst_err",       32'(err),       32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(3'b000, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5, 1'b1, 32'h00510093);
    drain();

`ifdef INST_ENC_CHECK_EN
    // Out-of-range immediates are consumed, dropped and flagged
    send(3'b000, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048, 1'b0, 32'd0);
    chk("chk_err_set", 32'(err), 32'd1);
    send(3'b111, 7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    drain();
    chk("chk_err_sticky", 32'(err), 32'd1);
    send(3'b101, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("chk_beq_dropped", 32'(out_valid), 32'd0);
    do_flush();
    chk("chk_err_after_flush", 32'(err), 32'd1);
`else
    // Reserved format dropped; large immediate truncated, no error
    send(3'b011, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rsv_dropped", 32'(out_valid), 32'd0);
    send(3'b000, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048, 1'b1, 32'h80010093);
    drain();
    chk("nochk_err", 32'(err), 32'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("final_empty", 32'(out_valid), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the main decode path: packs instruction descriptors (format, opcode, funct fields, register indices, immediate) into 32-bit RV32I instruction words.
- Buffers encoded words in a small FIFO.
- Emits each word with a sequential byte address for loading instruction memory, from a self-test sequencer or a debug loader.
- Valid/ready handshakes on both sides.

Parameters:
- FIFO_DEPTH, 4, entries in the output FIFO (power of two, ≥2).
- ADDR_W, 10, width of out_addr.
- BASE_ADDR, 0, first address emitted after reset or flush (multiple of 4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  encoder can accept a descriptor.
- fmt  in  3  format: 000 I, 001 S, 010 U, 101 B, 110 J, 111 R (I-type encoding also covers loads and jalr).
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25] for R and I-shift.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  immediate, full sign-extended value.
- flush  in  1  synchronous clear of FIFO and address.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- err  out  1  sticky illegal-descriptor flag (see Optional Feature).

Behaviour:
- Reset values: FIFO empty, out_valid=0, in_ready=1, out_instr=0, out_addr=BASE_ADDR, err=0.
- Push on in_valid && in_ready: encoded word written to FIFO at that edge. out_valid rises the next cycle; there is no combinational pass-through.
- in_ready = !full. When full, in_ready=0 even if out_ready=1 in the same cycle.
- Pop on out_valid && out_ready: head advances, out_addr += 4.
- out_addr wraps modulo 2^ADDR_W. out_instr/out_addr are stable while out_valid && !out_ready.
- Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
- Push into empty with out_ready=1: the word appears the next cycle.
- Occupancy is tracked with a count register (0..FIFO_DEPTH); pointers wrap at FIFO_DEPTH.
- Encoding:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode. Exception: if opcode=0010011 and funct3∈{001,101}, bits[31:25]=funct7 and bits[24:20]=imm[4:0].
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Reserved fmt (011, 100): descriptor is accepted and dropped, no push.
- flush: at that edge, count=0 and out_addr=BASE_ADDR. It overrides any same-cycle push and pop; in_ready stays 1 during flush. err is unaffected by flush.
- Reset asserted mid-operation: immediate clear to reset values regardless of clock.

Optional Feature:
- Macro INST_ENC_CHECK_EN.
- Defined: each accepted descriptor is range-checked.
  - I/S: imm must sign-fit 12 bits.
  - B: must sign-fit 13 bits with imm[0]=0.
  - J: must sign-fit 21 bits with imm[0]=0.
  - U: imm[11:0] must be 0.
  - I-shift: imm[11:5] must be 0.
  - Reserved fmt also fails.
  - A failing descriptor is consumed (in_ready handshake completes) but not pushed, and err is set to 1 until reset.
- Not defined: no checking; out-of-range bits are silently truncated per the encoding rules; err tied to 0.

Test Plan:
- addi x1,x2,5 (fmt I, op 0010011, f3 000, rd1 rs1 2, imm 5), out_ready=1 → next cycle out_valid=1, out_instr=0x00510093, out_addr=0x000.
- add x3,x1,x2 then sw x5,8(x6) back-to-back → 0x002081B3 @0x000, then 0x00532423 @0x004; srai x1,x1,3 (funct7 0100000) → 0x4030D093.
- beq x1,x2,-4 (fmt B, imm 0xFFFFFFFC) → 0xFE208EE3.
- out_ready=0, 5 pushes → in_ready=0 after 4th, 5th held; then out_ready=1 → addresses 0x000,0x004,0x008,0x00C,0x010 in order, no word lost or duplicated.
- 3 words queued, flush with concurrent push → out_valid=0 next cycle, next push emitted at BASE_ADDR; async rst_n pulse mid-stream → all outputs at reset values immediately.
- With INST_ENC_CHECK_EN: addi imm=2048 → no push, err=1 and sticky; beq imm=3 → no push. Without the macro: same addi emits 0x80010093, err=0.
